// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by pipe_hazard_ctrl and hazard_fwd_sel.
package pipe_ctrl_pkg;

   // Sequencer state encoding (kept as plain constants for legacy tools)
   typedef logic [1:0] state_t;
   localparam state_t RUN      = 2'd0;
   localparam state_t MEM_WAIT = 2'd1;
   localparam state_t ERR      = 2'd2;

   // E-stage operand forwarding selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage source operand.
// The youngest producer (M) wins over W; x0 is never forwarded.
module hazard_fwd_sel
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs,
   input  logic       reg_write_m,
   input  logic [4:0] rd_m,
   input  logic       reg_write_w,
   input  logic [4:0] rd_w,
   output logic [1:0] fwd
);

   // Pick the most recent in-flight writer of rs, else the register file
   // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      fwd = FWD_RF;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         fwd = FWD_MEM;
      end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RISC-V pipeline.
// Decides stall/flush of every stage register, E-stage forwarding, and
// freezes the pipe while a data-memory access is outstanding.
// Optional feature macro: HAZARD_PERF_EN adds saturating StallCnt/FlushCnt.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             RegWriteM,
   input  logic [4:0]       RdM,
   input  logic             RegWriteW,
   input  logic [4:0]       RdW,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErr
`ifdef HAZARD_PERF_EN
   , output logic [CNT_W-1:0] StallCnt
   , output logic [CNT_W-1:0] FlushCnt
`endif
);

   localparam int            CW       = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          lw_stall;
   logic          hold;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;

   hazard_fwd_sel u_fwd_a (
      .rs          (Rs1E),
      .reg_write_m (RegWriteM),
      .rd_m        (RdM),
      .reg_write_w (RegWriteW),
      .rd_w        (RdW),
      .fwd         (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .rs          (Rs2E),
      .reg_write_m (RegWriteM),
      .rd_m        (RdM),
      .reg_write_w (RegWriteW),
      .rd_w        (RdW),
      .fwd         (fwd_b)
   );

   // Forwarding is pure combinational; forced to the register file while in reset
   assign ForwardAE = rst_n ? fwd_a : FWD_RF;
   assign ForwardBE = rst_n ? fwd_b : FWD_RF;

   // Load in E whose result is needed by the instruction in D
   assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // Whole pipe frozen: error, or memory not ready while a request starts or is pending
   assign hold = (state == ERR) ||
                 (!MemReadyM && ((state == MEM_WAIT) || MemReqM));

   // Stall/flush decode: reset bubbles, then freeze, then branch over load-use
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!rst_n) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else if (hold) begin
         // W gets bubbles so the waiting load cannot write back twice
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   // Sequencer: tracks outstanding memory access and its timeout
   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         cnt    <= '0;
         MemErr <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (MemReqM && !MemReadyM) begin
                  state <= MEM_WAIT;
                  cnt   <= CW'(1);
               end
            end
            MEM_WAIT: begin
               if (MemReadyM) begin
                  state <= RUN;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state  <= ERR;
                  MemErr <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   // Saturating counts of fetch-stall cycles and branch flushes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (StallF && (StallCnt != '1)) begin
            StallCnt <= StallCnt + CNT_W'(1);
         end
         if (PCSrcE && FlushD && (FlushCnt != '1)) begin
            FlushCnt <= FlushCnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level reference model of the pipeline rules.
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
   localparam int CNT_W = 32;
   logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
      .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
      , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
   );

   // Observed outputs packed: StallF,D,E,M | FlushD,E,W | ForwardAE | ForwardBE | MemErr
   logic [11:0] got;
   assign got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                 ForwardAE, ForwardBE, MemErr};

   int checks = 0;
   int errors = 0;

   // Reference model: count of consecutive cycles the memory has kept us waiting
   int     waited;
   bit     err_m;
   longint stall_cnt_m, flush_cnt_m;

   function automatic logic [1:0] fwd_rule(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [11:0] expect_now();
      logic [6:0] sf;   // StallF,D,E,M, FlushD,E,W
      bit waiting, lw;
      if (!rst_n) return 12'b0000_1110_0000;
      lw      = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      waiting = err_m || (!MemReadyM && (waited > 0 || MemReqM));
      if (waiting)     sf = 7'b1111_001;
      else if (PCSrcE) sf = 7'b0000_110;
      else if (lw)     sf = 7'b1100_010;
      else             sf = 7'b0000_000;
      return {sf, fwd_rule(Rs1E), fwd_rule(Rs2E), err_m};
   endfunction

   // Clock edge: update the model with the inputs seen at the edge
   task automatic advance();
      logic [11:0] e;
      e = expect_now();
      @(posedge clk);
      if (rst_n) begin
         if (e[11] && stall_cnt_m < 64'hFFFF_FFFF) stall_cnt_m++;
         if (PCSrcE && e[7] && flush_cnt_m < 64'hFFFF_FFFF) flush_cnt_m++;
         if (!err_m) begin
            if (!MemReadyM && (waited > 0 || MemReqM)) begin
               waited++;
               if (waited == MEM_TIMEOUT) err_m = 1'b1;
            end else begin
               waited = 0;
            end
         end
      end
      #1;
   endtask

   task automatic clear_inputs();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
   endtask

   task automatic model_reset();
      waited = 0; err_m = 1'b0; stall_cnt_m = 0; flush_cnt_m = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      // Assert reset asynchronously with forwarding and hazards present
      rst_n = 1'b0; model_reset();
      Rs1E = 5'd3; Rs2E = 5'd3; RegWriteM = 1'b1; RdM = 5'd3;
      PCSrcE = 1'b1; MemReqM = 1'b1;
      #2;
      checks++;
      if (got !== 12'b0000_1110_0000) begin
         errors++; $display("FAIL reset_outputs: got %b expected %b", got, 12'b0000_1110_0000);
      end
      @(negedge clk);
      checks++;
      if (got !== expect_now()) begin
         errors++; $display("FAIL reset_hold: got %b expected %b", got, expect_now());
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (got !== 12'b0) begin
         errors++; $display("FAIL reset_release_idle: got %b expected %b", got, 12'b0);
      end
   endtask

   task automatic test_forwarding();
      do_reset();
      Rs1E = 5'd5; Rs2E = 5'd5; RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
      @(negedge clk);
      checks++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
         errors++; $display("FAIL fwd_mem_priority: got A=%b B=%b expected 10/10", ForwardAE, ForwardBE);
      end
      RdM = 5'd0;
      #1;
      checks++;
      if (ForwardAE !== 2'b01) begin
         errors++; $display("FAIL fwd_rdm_zero: got %b expected 01", ForwardAE);
      end
      RdW = 5'd0;
      #1;
      checks++;
      if (ForwardAE !== 2'b00) begin
         errors++; $display("FAIL fwd_x0_never: got %b expected 00", ForwardAE);
      end
      advance();
   endtask

   task automatic test_load_use();
      do_reset();
      ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      @(negedge clk);
      checks++;
      if (got !== 12'b1100_0100_0000) begin
         errors++; $display("FAIL load_use_stall: got %b expected %b", got, 12'b1100_0100_0000);
      end
      advance();
      // Bubble now sits in E
      ResultSrcE0 = 1'b0; RdE = 5'd0;
      @(negedge clk);
      checks++;
      if (got !== 12'b0) begin
         errors++; $display("FAIL load_use_after: got %b expected %b", got, 12'b0);
      end
      advance();
   endtask

   task automatic test_branch_priority();
      do_reset();
      ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9; PCSrcE = 1'b1;
      @(negedge clk);
      checks++;
      if (got !== 12'b0000_1100_0000) begin
         errors++; $display("FAIL branch_over_load: got %b expected %b", got, 12'b0000_1100_0000);
      end
      advance();
      PCSrcE = 1'b0;
   endtask

   task automatic test_mem_wait();
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (got[11:5] !== 7'b1111_001) begin
            errors++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, got[11:5], 7'b1111_001);
         end
         advance();
      end
      MemReadyM = 1'b1;
      @(negedge clk);
      checks++;
      if (got !== 12'b0) begin
         errors++; $display("FAIL mem_release: got %b expected %b", got, 12'b0);
      end
      advance();
      MemReqM = 1'b0; MemReadyM = 1'b0;
      @(negedge clk);
      checks++;
      if (got !== 12'b0) begin
         errors++; $display("FAIL mem_back_to_run: got %b expected %b", got, 12'b0);
      end
      advance();
      PCSrcE = 1'b1;
      advance();
      PCSrcE = 1'b0;
`ifdef HAZARD_PERF_EN
      @(negedge clk);
      checks++;
      if (StallCnt !== 32'd3 || FlushCnt !== 32'd1) begin
         errors++; $display("FAIL perf_counts: got stall=%0d flush=%0d expected 3/1", StallCnt, FlushCnt);
      end
`endif
   endtask

   task automatic test_timeout();
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT + 4; i++) begin
         if (i >= MEM_TIMEOUT + 2) MemReadyM = 1'b1;   // too late: error is sticky
         @(negedge clk);
         checks++;
         if (MemErr !== (i >= MEM_TIMEOUT) || got[11:5] !== 7'b1111_001) begin
            errors++;
            $display("FAIL timeout[%0d]: got err=%b ctl=%b expected err=%b ctl=%b",
                     i, MemErr, got[11:5], (i >= MEM_TIMEOUT), 7'b1111_001);
         end
         advance();
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (got !== 12'b0) begin
         errors++; $display("FAIL timeout_reset_clears: got %b expected %b", got, 12'b0);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         ResultSrcE0 = 1'($urandom % 3 == 0);
         PCSrcE      = 1'($urandom % 5 == 0);
         RegWriteM   = 1'($urandom % 2);
         RegWriteW   = 1'($urandom % 2);
         MemReqM     = 1'($urandom % 4 == 0);
         MemReadyM   = 1'($urandom % 3 != 0);
         @(negedge clk);
         checks++;
         if (got !== expect_now()) begin
            errors++; $display("FAIL random[%0d]: got %b expected %b", n, got, expect_now());
         end
`ifdef HAZARD_PERF_EN
         checks++;
         if (StallCnt !== stall_cnt_m[31:0] || FlushCnt !== flush_cnt_m[31:0]) begin
            errors++;
            $display("FAIL random_perf[%0d]: got %0d/%0d expected %0d/%0d",
                     n, StallCnt, FlushCnt, stall_cnt_m, flush_cnt_m);
         end
`endif
         advance();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
